// File: rtl/rv_bus_pkg.sv
// rv_bus_pkg: shared types and constants for the CPU system-bus arbiter.
//   bus_state_t     : sequencer states (IDLE, ISSUE, WAIT)
//   bus_src_t       : which requester owns the current transaction
//   BE_ALL          : byte enables used for every instruction fetch
//   RV_BUS_ERR_DATA : read data returned on an aborted transaction
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } bus_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } bus_src_t;

  localparam logic [3:0]  BE_ALL          = 4'hF;
  localparam logic [31:0] RV_BUS_ERR_DATA = 32'h0;

endpackage

// File: rtl/rv_bus_if.sv
// rv_bus_if: external CPU system bus.
//   ads      address valid, one cycle per transaction
//   rd_wr_n  1 = read, 0 = write
//   i_dn     1 = instruction, 0 = data
//   addr     bus address
//   be       byte enables
//   wr_data  write data
//   rd_data  read data, sampled on ack
//   ack      transaction complete
// master: the arbiter side; slave: the memory side.
interface rv_bus_if;
  logic        ads;
  logic        rd_wr_n;
  logic        i_dn;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;

  modport master (
    output ads, rd_wr_n, i_dn, addr, be, wr_data,
    input  rd_data, ack
  );

  modport slave (
    input  ads, rd_wr_n, i_dn, addr, be, wr_data,
    output rd_data, ack
  );
endinterface

// File: rtl/rv_bus_wdog.sv
// rv_bus_wdog: WAIT-phase timeout counter, used only when RV_BUS_TIMEOUT_EN
// is defined.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (asserted the cycle before WAIT is entered)
//   en         : a WAIT cycle is in progress
//   expire     : this WAIT cycle is the TIMEOUT_CYCLES-th one without ack
module rv_bus_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the number of WAIT cycles already elapsed, so the expiring
  // cycle is the one where cnt is one short of the limit.
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/rv_bus_arb.sv
// rv_bus_arb: shares the CPU system bus between instruction fetch (IF) and
// load/store (D). One transaction at a time: arbitrate in IDLE, drive ads and
// the winner's grant for one ISSUE cycle, hold the address phase in WAIT until
// ack, then pulse the winner's done in the following IDLE cycle.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr               IF read request (held until if_gnt)
//   if_gnt/if_done/if_rdata      IF grant pulse, completion pulse, fetched word
//   d_req/d_we/d_addr/d_be/d_wdata   D request and attributes (held until d_gnt)
//   d_gnt/d_done/d_rdata         D grant pulse, completion pulse, load data
//   bus_err                      with a done pulse: transaction timed out
//   bus                          rv_bus_if master (external memory bus)
//
// Optional feature macro: RV_BUS_TIMEOUT_EN adds a WAIT timeout of
// TIMEOUT_CYCLES cycles; without it WAIT lasts until ack and bus_err is 0.
//
// state | meaning
// IDLE  | no transaction; arbitrate any pending request
// ISSUE | ads and the winner's gnt asserted for one cycle
// WAIT  | address phase held; waiting for ack (or timeout)
module rv_bus_arb
  import rv_bus_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  rv_bus_if.master    bus
);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
    $error("rv_bus_arb: MAX_D_STREAK must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rv_bus_arb: TIMEOUT_CYCLES must be 1..255");
  end

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  bus_state_t state;
  bus_src_t   src;
  logic [3:0] streak;
  logic       pick_d;
  logic       to_abort;

  // D has priority except when it has already starved a waiting IF for
  // STREAK_MAX grants in a row.
  assign pick_d = d_req && !(if_req && streak == STREAK_MAX);

`ifdef RV_BUS_TIMEOUT_EN
  logic wdog_expire;
  logic err_q;

  rv_bus_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .expire (wdog_expire)
  );

  // A same-cycle ack wins over expiry and completes normally.
  assign to_abort = (state == WAIT) && !bus.ack && wdog_expire;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= to_abort;
  end

  assign bus_err = err_q;
`else
  assign to_abort = 1'b0;
  assign bus_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src         <= SRC_IF;
      streak      <= '0;
      bus.ads     <= 1'b0;
      bus.rd_wr_n <= 1'b1;
      bus.i_dn    <= 1'b1;
      bus.addr    <= '0;
      bus.be      <= '0;
      bus.wr_data <= '0;
      if_gnt      <= 1'b0;
      d_gnt       <= 1'b0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      bus.ads <= 1'b0;
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ISSUE;
            bus.ads <= 1'b1;
            if (pick_d) begin
              src         <= SRC_D;
              d_gnt       <= 1'b1;
              bus.i_dn    <= 1'b0;
              bus.rd_wr_n <= ~d_we;
              bus.addr    <= d_addr;
              bus.be      <= d_be;
              bus.wr_data <= d_we ? d_wdata : 32'h0;
              if (!if_req)                   streak <= '0;
              else if (streak != STREAK_MAX) streak <= streak + 4'd1;
            end else begin
              src         <= SRC_IF;
              if_gnt      <= 1'b1;
              bus.i_dn    <= 1'b1;
              bus.rd_wr_n <= 1'b1;
              bus.addr    <= if_addr;
              bus.be      <= BE_ALL;
              bus.wr_data <= 32'h0;
              streak      <= '0;
            end
          end
        end

        ISSUE: state <= WAIT;

        WAIT: begin
          if (bus.ack) begin
            state <= IDLE;
            if (src == SRC_IF) begin
              if_done  <= 1'b1;
              if_rdata <= bus.rd_data;
            end else begin
              d_done <= 1'b1;
              // Writes complete without disturbing the last load result.
              if (bus.rd_wr_n) d_rdata <= bus.rd_data;
            end
          end else if (to_abort) begin
            state <= IDLE;
            if (src == SRC_IF) begin
              if_done  <= 1'b1;
              if_rdata <= RV_BUS_ERR_DATA;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= RV_BUS_ERR_DATA;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_bus_arb.sv
module tb_rv_bus_arb;
  import rv_bus_pkg::*;

  localparam int MAXS = 4;
`ifdef RV_BUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        bus_err;

  rv_bus_if bus ();

  rv_bus_arb #(
    .MAX_D_STREAK   (MAXS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_be     (d_be),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .bus_err  (bus_err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t if_stim[$];
  txn_t d_stim[$];
  txn_t exp_q[$];
  bit   glog[$];

  int total = 0;
  int bad   = 0;
  int streak_m = 0;

  int          resp_mode   = 0;   // 0 normal, 1 never ack, 2 one late ack
  int          fix_lat     = 0;
  bit          fix_data_en = 1'b0;
  logic [31:0] fix_data    = '0;
  bit          ack_real;
  logic [31:0] ack_val;

  bit          inflight = 1'b0, waiting = 1'b0, done_due = 1'b0, due_err = 1'b0;
  txn_t        cur;
  logic [31:0] cur_data = '0;
  logic [31:0] d_track  = '0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic txn_t mk(bit is_d, bit we, logic [31:0] a, logic [3:0] b, logic [31:0] w);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = a; t.be = b; t.wdata = w;
    return t;
  endfunction

  // Reference arbitration: a requester with work left keeps its req high,
  // so each arbitration sees exactly the requesters with non-empty queues.
  task automatic plan_batch();
    int i, j;
    bit ip, dp;
    i = 0; j = 0;
    while (i < if_stim.size() || j < d_stim.size()) begin
      ip = (i < if_stim.size());
      dp = (j < d_stim.size());
      if (dp && !(ip && streak_m == MAXS)) begin
        exp_q.push_back(d_stim[j]); j++;
        if (ip) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
        else    streak_m = 0;
      end else begin
        exp_q.push_back(if_stim[i]); i++;
        streak_m = 0;
      end
    end
  endtask

  task automatic drive_if();
    int n;
    for (int k = 0; k < if_stim.size(); k++) begin
      if_req  = 1'b1;
      if_addr = if_stim[k].addr;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!if_gnt && n < 500);
      chk("if_gnt_wait", 32'(if_gnt), 32'd1);
    end
    if_req = 1'b0;
  endtask

  task automatic drive_d();
    int n;
    for (int k = 0; k < d_stim.size(); k++) begin
      d_req   = 1'b1;
      d_we    = d_stim[k].we;
      d_addr  = d_stim[k].addr;
      d_be    = d_stim[k].be;
      d_wdata = d_stim[k].wdata;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!d_gnt && n < 500);
      chk("d_gnt_wait", 32'(d_gnt), 32'd1);
    end
    d_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || inflight || done_due) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(exp_q.size()) + 32'(inflight) + 32'(done_due), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_batch();
    plan_batch();
    fork
      drive_if();
      drive_d();
    join
    wait_idle();
    if_stim.delete();
    d_stim.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ads"},     32'(bus.ads), 32'd0);
    chk({tag, "_gnt"},     32'({if_gnt, d_gnt}), 32'd0);
    chk({tag, "_done"},    32'({if_done, d_done, bus_err}), 32'd0);
    chk({tag, "_rw_idn"},  32'({bus.rd_wr_n, bus.i_dn}), 32'd3);
    chk({tag, "_addr"},    bus.addr, 32'd0);
    chk({tag, "_be"},      32'(bus.be), 32'd0);
    chk({tag, "_wdata"},   bus.wr_data, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Memory responder: acks each transaction 1..4 cycles after ads, sometimes
  // with a stray ack during ISSUE that the arbiter must ignore.
  initial begin
    int lat;
    bus.ack = 1'b0; bus.rd_data = '0; ack_real = 1'b0; ack_val = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack = 1'b0; ack_real = 1'b0; bus.rd_data = $urandom;
      if (bus.ads && resp_mode != 1) begin
        if (resp_mode == 2) begin
          @(posedge clk); #1;
          @(posedge clk); #1;
          bus.ack = 1'b1;
        end else begin
          lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
          bus.ack = ($urandom_range(0, 3) == 0);
          for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            bus.ack = 1'b0; bus.rd_data = $urandom;
          end
          ack_val     = fix_data_en ? fix_data : $urandom;
          bus.rd_data = ack_val;
          bus.ack     = 1'b1;
          ack_real    = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard, sampling at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 1'b0; waiting = 1'b0; done_due = 1'b0; d_track = '0;
        continue;
      end
      if (done_due) begin
        done_due = 1'b0;
        inflight = 1'b0;
        chk("done_sel", 32'({if_done, d_done}), cur.is_d ? 32'd1 : 32'd2);
        chk("bus_err", 32'(bus_err), 32'(due_err));
        if (!cur.is_d) begin
          chk("if_rdata", if_rdata, due_err ? 32'd0 : cur_data);
        end else begin
          if (due_err)      d_track = '0;
          else if (!cur.we) d_track = cur_data;
          chk("d_rdata", d_rdata, d_track);
        end
      end else begin
        chk("no_done", 32'({if_done, d_done, bus_err}), 32'd0);
      end

      if (bus.ads) begin
        if (exp_q.size() == 0) begin
          chk("ads_unexpected", 32'(bus.ads), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          glog.push_back(d_gnt);
          chk("gnt", 32'({if_gnt, d_gnt}), cur.is_d ? 32'd1 : 32'd2);
          chk("addr", bus.addr, cur.addr);
          chk("be_rw_idn", 32'({bus.be, bus.rd_wr_n, bus.i_dn}),
              32'({cur.is_d ? cur.be : 4'hF, !(cur.is_d && cur.we), !cur.is_d}));
          chk("wr_data", bus.wr_data, (cur.is_d && cur.we) ? cur.wdata : 32'd0);
          inflight = 1'b1; waiting = 1'b1; wcnt = 0;
        end
      end else begin
        chk("gnt_quiet", 32'({if_gnt, d_gnt}), 32'd0);
        if (waiting) begin
          chk("hold_addr", bus.addr, cur.addr);
          chk("hold_attr", 32'({bus.be, bus.rd_wr_n, bus.i_dn}),
              32'({cur.is_d ? cur.be : 4'hF, !(cur.is_d && cur.we), !cur.is_d}));
          chk("hold_wdata", bus.wr_data, (cur.is_d && cur.we) ? cur.wdata : 32'd0);
          wcnt++;
          if (ack_real) begin
            waiting = 1'b0; done_due = 1'b1; due_err = 1'b0; cur_data = ack_val;
          end
`ifdef RV_BUS_TIMEOUT_EN
          else if (wcnt == TO) begin
            waiting = 1'b0; done_due = 1'b1; due_err = 1'b1;
          end
`endif
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    logic [7:0] ord;
    txn_t t;

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // IF fetch, ack two cycles after ads
    fix_lat = 2; fix_data_en = 1'b1; fix_data = 32'h0050_0093;
    if_stim.push_back(mk(1'b0, 1'b0, 32'h100, 4'hF, 32'h0));
    run_batch();
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);

    // D write; load data register must not change
    fix_data = 32'h1234_5678;
    d_stim.push_back(mk(1'b1, 1'b1, 32'h2000, 4'b0011, 32'hCAFE_BABE));
    run_batch();
    chk("t2_d_rdata_kept", d_rdata, 32'h0);
    fix_lat = 0; fix_data_en = 1'b0;

    // simultaneous requests: D first, then IF
    base = glog.size();
    if_stim.push_back(mk(1'b0, 1'b0, 32'h0000_0400, 4'hF, 32'h0));
    d_stim.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 4'hC, 32'h5555_AAAA));
    run_batch();
    ord = '0;
    for (int k = 0; k < 2; k++) ord = {ord[6:0], glog[base + k]};
    chk("t3_order", 32'(ord), 32'h2);

    // IF held while D streams: D D D D IF D D IF
    base = glog.size();
    for (int k = 0; k < 2; k++) if_stim.push_back(mk(1'b0, 1'b0, 32'h500 + 32'(4 * k), 4'hF, 32'h0));
    for (int k = 0; k < 6; k++) d_stim.push_back(mk(1'b1, k[0], 32'h4000 + 32'(4 * k), 4'hF, 32'h1000 + 32'(k)));
    run_batch();
    ord = '0;
    for (int k = 0; k < 8; k++) ord = {ord[6:0], glog[base + k]};
    chk("t4_order", 32'(ord), 32'hF6);

    // random mixes
    for (int b = 0; b < 25; b++) begin
      int ni, nd;
      ni = $urandom_range(0, 4);
      nd = $urandom_range(0, 5);
      for (int k = 0; k < ni; k++) if_stim.push_back(mk(1'b0, 1'b0, $urandom & 32'hFFFF_FFFC, 4'hF, 32'h0));
      for (int k = 0; k < nd; k++) begin
        t = mk(1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
        d_stim.push_back(t);
      end
      run_batch();
    end

    // reset pulsed during WAIT, then a late ack
    resp_mode = 2;
    if_stim.push_back(mk(1'b0, 1'b0, 32'h0000_0600, 4'hF, 32'h0));
    plan_batch();
    drive_if();
    if_stim.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    streak_m = 0;
    chk_reset_vals("wrst");
    @(posedge clk); #1;
    chk("wrst_no_done", 32'({if_done, d_done, bus.ads}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wrst_quiet", 32'({if_done, d_done, bus.ads}), 32'd0);
    resp_mode = 0;
    fix_data_en = 1'b1; fix_data = 32'hA5A5_0001;
    if_stim.push_back(mk(1'b0, 1'b0, 32'h0000_0700, 4'hF, 32'h0));
    run_batch();
    chk("post_rst_if_rdata", if_rdata, 32'hA5A5_0001);
    fix_data_en = 1'b0;

`ifdef RV_BUS_TIMEOUT_EN
    // D read never acked, then a normal request
    resp_mode = 1;
    d_stim.push_back(mk(1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0));
    run_batch();
    chk("to_d_rdata", d_rdata, 32'h0);
    resp_mode = 0;
    fix_data_en = 1'b1; fix_data = 32'h0BAD_F00D;
    d_stim.push_back(mk(1'b1, 1'b0, 32'h0000_8004, 4'hF, 32'h0));
    run_batch();
    chk("to_next_d_rdata", d_rdata, 32'h0BAD_F00D);
    fix_data_en = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
